i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares one I2C_master instance between NREQ requesters. It latches a requester's address, rw and write byte, launches a single-byte I2C transaction, and tracks the master's ready handshake to completion. It returns read data and signals done or error per requester. It detects master errors and hangs and recovers by pulsing the master's active-high reset.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 4096, clk cycles allowed in any wait state before a hang is declared
RST_CYCLES, 8, clk cycles m_rst is held high during recovery (must cover ≥2 master i2c_clk edges)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
req  in  NREQ  per-requester request level; hold until own done/err pulse
req_addr  in  7*NREQ  7-bit slave address, requester i at [7i+6:7i]
req_rw  in  NREQ  1=read, 0=write
req_wdata  in  8*NREQ  write byte, requester i at [8i+7:8i]
gnt  out  NREQ  one-hot grant, high from grant until completion
done  out  NREQ  one-cycle pulse, transaction completed OK
err  out  NREQ  one-cycle pulse, transaction failed (NACK/error/timeout)
rdata  out  8  read byte, valid with done of a read
busy  out  1  high whenever state != IDLE
m_addr  out  7  to master addr
m_rw  out  1  to master rw
m_data_in  out  8  to master data_in
m_start  out  1  to master start
m_more_data  out  1  to master more_data, constant 0 (single-byte only)
m_rst  out  1  to master rst, active-high
m_ready  in  1  from master ready
m_error  in  1  from master error_flag (sticky until master reset)
m_data_out  in  8  from master data_out

Behaviour:
- All outputs registered. Reset (rst=0 at posedge clk): gnt=0, done=0, err=0, rdata=0, busy=0, m_addr=0, m_rw=0, m_data_in=0, m_start=0, m_more_data=0, m_rst=1, rr_ptr=NREQ-1, timer=0, state=IDLE. First cycle after rst release: m_rst=0.
- States: IDLE, LAUNCH, ACTIVE, COMPLETE, RECOVER.
- IDLE: if any req bit is set and m_ready=1 and m_error=0, grant the first set bit searching from rr_ptr+1 upward with wrap. Latch that requester's addr/rw/wdata into m_*, set gnt, set rr_ptr=winner, assert m_start, timer=0, go to LAUNCH. If m_error=1 in IDLE, go to RECOVER with no err pulse.
- LAUNCH: hold m_start=1. On m_ready=0 (master left IDLE), set m_start=0 and go to ACTIVE, timer=0.
- ACTIVE: if m_error=1, go to RECOVER with fail flag set. On m_ready=1, capture m_data_out into rdata if m_rw=1 and go to COMPLETE.
- COMPLETE: pulse done[winner] one cycle, clear gnt, go to IDLE. rdata holds until the next read completes.
- RECOVER: m_rst=1 for RST_CYCLES cycles. On entry, pulse err[winner] one cycle if fail flag is set, and clear gnt. On exit, m_rst=0 and go to IDLE. No grant is issued until m_ready=1 and m_error=0.
- Timeout: timer counts each cycle in LAUNCH or ACTIVE. When timer reaches TIMEOUT-1, go to RECOVER with fail flag set. Timer width is clog2(TIMEOUT).
- Requester dropping req mid-transaction: ignored. The transaction completes and done/err still pulses.
- Requester holding req after done: eligible again, but rr_ptr gives every other pending requester priority first. The granted index therefore cannot repeat while another requester is pending.
- Simultaneous m_error and m_ready rise in ACTIVE: error wins, go to RECOVER.
- Request fields changing after grant: no effect, since they were latched at grant.
- rst asserted mid-transaction: immediate return to reset values. m_rst=1 forces the master back to IDLE.
- Exactly one of done/err pulses per granted transaction. They never pulse for an ungranted requester.

Test Plan:
- Single write: req[0]=1, addr=0x50, rw=0, wdata=0xA5, ACKing slave model -> gnt=01, m_start until m_ready falls, 0xA0,0xA5 on SDA, done[0] pulse, err=0.
- Read: req[1]=1, addr=0x3C, rw=1, slave returns 0x5A -> rdata=0x5A in the done[1] cycle; rdata holds 0x5A after req[1] drops.
- Fairness: req=11 held continuously for 4 transactions -> grant order 0,1,0,1. Exactly 4 done pulses.
- NACK: slave does not ACK address 0x22 -> m_error=1, err[0] pulse, m_rst high 8 cycles. Next req[1] write then completes with done[1].
- Hang: slave stretches/holds so m_ready stays 0 -> err pulse exactly TIMEOUT cycles after LAUNCH/ACTIVE entry, then RECOVER, then IDLE.
- Reset mid-ACTIVE: rst=0 for one cycle during a data byte -> all outputs at reset values and m_rst=1. No done/err pulse. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_txn_arbiter
//
// Shares a single I2C master between NREQ requesters. A round-robin search
// picks one pending requester and latches its address, direction and write
// byte into the master. The arbiter then launches one single-byte
// transaction and follows the master's ready handshake until it completes.
// The winner gets a one-cycle done pulse (with read data) or a one-cycle err
// pulse. Master errors and hangs are cleared by holding the master's
// active-high reset for RST_CYCLES cycles.
//
// Ports:
//   clk, rst        system clock; synchronous active-low reset
//   req             per-requester request level (held until own done/err)
//   req_addr        7-bit slave address per requester, packed [7i+6:7i]
//   req_rw          per-requester direction, 1 = read
//   req_wdata       write byte per requester, packed [8i+7:8i]
//   gnt             one-hot grant, held from grant until completion
//   done / err      one-cycle completion / failure pulse for the winner
//   rdata           last read byte, updated with done of a read
//   busy            high whenever the sequencer is not idle
//   m_*             connection to the I2C master (m_rst is active-high)
// ---------------------------------------------------------------------------
module i2c_txn_arbiter #(
  parameter int NREQ       = 2,
  parameter int TIMEOUT    = 4096,
  parameter int RST_CYCLES = 8    // must not exceed TIMEOUT (shares the timer)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [8*NREQ-1:0]    req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_data_in,
  output logic                 m_start,
  output logic                 m_more_data,
  output logic                 m_rst,
  input  logic                 m_ready,
  input  logic                 m_error,
  input  logic [7:0]           m_data_out
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] RST_LAST   = TW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ACTIVE,
    S_COMPLETE,
    S_RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_data_in_q, m_data_in_d;
  logic            m_start_q, m_start_d;
  logic            m_rst_q, m_rst_d;
  logic            go_fail;

  // Candidate order for the round-robin search: cand_idx[0] is the requester
  // just after the last winner, cand_idx[NREQ-1] is the last winner itself.
  logic [PW-1:0] cand_idx [NREQ];
  logic [PW-1:0] win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      localparam int OFS = gi + 1;
      assign cand_idx[gi] = (int'(rr_ptr_q) + OFS >= NREQ)
                          ? PW'(int'(rr_ptr_q) + OFS - NREQ)
                          : PW'(int'(rr_ptr_q) + OFS);
    end
  endgenerate

  // Scan from the lowest priority upward so the last hit is the winner.
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_in_d = m_data_in_q;
    m_start_d   = m_start_q;
    m_rst_d     = m_rst_q;
    go_fail     = 1'b0;

    case (state_q)
      S_IDLE: begin
        m_rst_d = 1'b0;
        if (m_error) begin
          // Stale master error with nobody granted: recover silently.
          state_d = S_RECOVER;
          m_rst_d = 1'b1;
          timer_d = '0;
        end else if ((|req) && m_ready) begin
          state_d          = S_LAUNCH;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          rr_ptr_d         = win_idx;
          m_addr_d         = req_addr[7*win_idx +: 7];
          m_rw_d           = req_rw[win_idx];
          m_data_in_d      = req_wdata[8*win_idx +: 8];
          m_start_d        = 1'b1;
          timer_d          = '0;
        end
      end

      S_LAUNCH: begin
        // Start is held until the master acknowledges by dropping ready.
        if (!m_ready) begin
          m_start_d = 1'b0;
          state_d   = S_ACTIVE;
          timer_d   = '0;
        end else if (timer_q == TIMER_LAST) begin
          go_fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_ACTIVE: begin
        // Error takes precedence over a simultaneous ready.
        if (m_error) begin
          go_fail = 1'b1;
        end else if (m_ready) begin
          if (m_rw_q) begin
            rdata_d = m_data_out;
          end
          done_d  = gnt_q;
          state_d = S_COMPLETE;
        end else if (timer_q == TIMER_LAST) begin
          go_fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_COMPLETE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end

      S_RECOVER: begin
        if (timer_q == RST_LAST) begin
          m_rst_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Failed transaction: report to the current winner and reset the master.
    if (go_fail) begin
      state_d   = S_RECOVER;
      err_d     = gnt_q;
      gnt_d     = '0;
      m_start_d = 1'b0;
      m_rst_d   = 1'b1;
      timer_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= PW'(NREQ - 1);
      timer_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_in_q <= '0;
      m_start_q   <= 1'b0;
      m_rst_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_in_q <= m_data_in_d;
      m_start_q   <= m_start_d;
      m_rst_q     <= m_rst_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign m_addr      = m_addr_q;
  assign m_rw        = m_rw_q;
  assign m_data_in   = m_data_in_q;
  assign m_start     = m_start_q;
  assign m_rst       = m_rst_q;
  // Only single-byte transactions are issued.
  assign m_more_data = 1'b0;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_txn_arbiter
//
// Self-checking bench for i2c_txn_arbiter. A cycle-level I2C master model
// answers the start/ready handshake. It can complete normally, NACK (error
// together with ready), hang busy, or ignore start entirely. The
// expectations come from a transaction-level reference: round-robin winner
// from the pending mask, latched request fields, last read byte, timeout
// and recovery lengths in cycles.
// ---------------------------------------------------------------------------
module tb_i2c_txn_arbiter;

  localparam int NREQ       = 3;
  localparam int TIMEOUT    = 64;
  localparam int RST_CYCLES = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [7*NREQ-1:0]   req_addr;
  logic [NREQ-1:0]     req_rw;
  logic [8*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]     gnt, done, err;
  logic [7:0]          rdata;
  logic                busy;
  logic [6:0]          m_addr;
  logic                m_rw;
  logic [7:0]          m_data_in;
  logic                m_start, m_more_data, m_rst;
  logic                m_ready    = 1'b1;
  logic                m_error    = 1'b0;
  logic [7:0]          m_data_out = 8'h00;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  // Reference-model state
  int          last_win;
  logic [7:0]  exp_rdata;

  // Master model controls: 0 ack, 1 nack, 2 hang busy, 3 ignore start
  int          slave_mode  = 0;
  logic [7:0]  slave_rbyte = 8'h00;
  int          slave_dur   = 3;
  logic        inject_err  = 1'b0;
  logic        mbusy       = 1'b0;
  int          mcnt        = 0;

  logic [NREQ-1:0] gnt_prev = '0;
  int fair_order [4] = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_start(m_start), .m_more_data(m_more_data), .m_rst(m_rst),
    .m_ready(m_ready), .m_error(m_error), .m_data_out(m_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural I2C master: ready drops the cycle after start is seen.
  always @(posedge clk) begin
    if (m_rst === 1'b1) begin
      m_ready <= 1'b1;
      m_error <= 1'b0;
      mbusy   <= 1'b0;
    end else begin
      if (inject_err) m_error <= 1'b1;
      if (!mbusy) begin
        if (m_ready && m_start === 1'b1 && slave_mode != 3) begin
          m_ready <= 1'b0;
          mbusy   <= 1'b1;
          mcnt    <= slave_dur;
        end
      end else if (slave_mode != 2) begin
        if (mcnt == 0) begin
          mbusy   <= 1'b0;
          m_ready <= 1'b1;
          if (slave_mode == 1) m_error <= 1'b1;
          else m_data_out <= slave_rbyte;
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  // Pulses only ever go to the requester granted in the previous cycle.
  always @(negedge clk) begin
    if ((done | err) != '0) begin
      check("pulse_owner", 32'((done | err) & ~gnt_prev), 32'd0);
      check("done_err_excl", 32'(done & err), 32'd0);
    end
    if (done != '0) done_cnt++;
    gnt_prev <= gnt;
  end

  function automatic int next_winner(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_fields(input int i);
    req_addr[7*i +: 7]  = 7'($urandom);
    req_rw[i]           = 1'($urandom);
    req_wdata[8*i +: 8] = 8'($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt",       32'(gnt),         32'd0);
    check("rst_done",      32'(done),        32'd0);
    check("rst_err",       32'(err),         32'd0);
    check("rst_rdata",     32'(rdata),       32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_m_addr",    32'(m_addr),      32'd0);
    check("rst_m_rw",      32'(m_rw),        32'd0);
    check("rst_m_data_in", 32'(m_data_in),   32'd0);
    check("rst_m_start",   32'(m_start),     32'd0);
    check("rst_m_more",    32'(m_more_data), 32'd0);
    check("rst_m_rst",     32'(m_rst),       32'd1);
  endtask

  // One complete transaction: grant, launch, outcome, recovery if failed.
  task automatic run_txn(input int idx, input int mode, input logic [7:0] rbyte, input bit drop_early);
    logic [6:0] ea;
    logic       ew;
    logic [7:0] ed;
    int c, a_cycle, k;
    ea = req_addr[7*idx +: 7];
    ew = req_rw[idx];
    ed = req_wdata[8*idx +: 8];
    slave_mode  = mode;
    slave_rbyte = rbyte;
    slave_dur   = $urandom_range(1, 8);
    c = 0;
    do begin @(negedge clk); c++; end while (gnt == '0 && c < 200);
    check("gnt",       32'(gnt),       32'(1 << idx));
    check("m_addr",    32'(m_addr),    32'(ea));
    check("m_rw",      32'(m_rw),      32'(ew));
    check("m_data_in", 32'(m_data_in), 32'(ed));
    check("m_start",   32'(m_start),   32'd1);
    last_win = idx;
    // Fields changing after grant must not reach the master.
    rand_fields(idx);
    if (drop_early) req[idx] = 1'b0;
    c = 0;
    a_cycle = -1;
    do begin
      @(negedge clk);
      c++;
      if (a_cycle < 0 && m_start == 1'b0) a_cycle = c;
    end while (done == '0 && err == '0 && c < TIMEOUT + 64);
    if (mode != 3) check("launch_len", 32'(a_cycle), 32'd2);
    if (mode == 0) begin
      check("done",        32'(done),   32'(1 << idx));
      check("err",         32'(err),    32'd0);
      if (ew) exp_rdata = rbyte;
      check("rdata",       32'(rdata),  32'(exp_rdata));
      check("m_addr_hold", 32'(m_addr), 32'(ea));
    end else begin
      check("err",     32'(err),  32'(1 << idx));
      check("done",    32'(done), 32'd0);
      check("gnt_clr", 32'(gnt),  32'd0);
      if (mode == 2) check("hang_active_to", 32'(c - a_cycle), 32'(TIMEOUT));
      if (mode == 3) check("hang_launch_to", 32'(c), 32'(TIMEOUT));
      k = 0;
      while (m_rst == 1'b1 && k < 100) begin @(negedge clk); k++; end
      check("m_rst_len",      32'(k),    32'(RST_CYCLES));
      check("busy_after_rec", 32'(busy), 32'd0);
    end
    $display("txn req=%0d mode=%0d rw=%0d addr=0x%02h wdata=0x%02h done=%b err=%b rdata=0x%02h",
             idx, mode, ew, ea, ed, done, err, rdata);
    slave_mode = 0;
  endtask

  initial begin
    int n0, c, k, w, m, mode;
    logic [NREQ-1:0] seen;

    rst = 1'b0; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    check("m_rst_release", 32'(m_rst), 32'd0);
    check("busy_release",  32'(busy),  32'd0);
    last_win  = NREQ - 1;
    exp_rdata = 8'h00;

    // Single write from requester 0
    req_addr[0 +: 7] = 7'h50; req_rw[0] = 1'b0; req_wdata[0 +: 8] = 8'hA5; req[0] = 1'b1;
    run_txn(0, 0, 8'h00, 1'b0);
    req[0] = 1'b0;

    // Read from requester 1, data must persist after the request drops
    req_addr[7 +: 7] = 7'h3C; req_rw[1] = 1'b1; req[1] = 1'b1;
    run_txn(1, 0, 8'h5A, 1'b0);
    req[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("rdata_hold", 32'(rdata), 32'h5A);

    // Fairness with both requesters held
    n0 = done_cnt;
    req_rw[1:0] = 2'b00;
    req = 3'b011;
    for (int t = 0; t < 4; t++) run_txn(fair_order[t], 0, 8'($urandom), 1'b0);
    req = '0;
    @(negedge clk);
    check("fair_done_cnt", 32'(done_cnt - n0), 32'd4);

    // NACK on requester 0, then a clean write from requester 1
    req_addr[0 +: 7] = 7'h22; req_rw[0] = 1'b0; req[0] = 1'b1;
    run_txn(0, 1, 8'h00, 1'b0);
    req[0] = 1'b0;
    req_addr[7 +: 7] = 7'h11; req_rw[1] = 1'b0; req_wdata[8 +: 8] = 8'h3C; req[1] = 1'b1;
    run_txn(1, 0, 8'h00, 1'b0);
    req[1] = 1'b0;

    // Hang while busy, then a master that never takes the start
    rand_fields(0); req[0] = 1'b1;
    run_txn(0, 2, 8'h00, 1'b0);
    req[0] = 1'b0;
    rand_fields(1); req[1] = 1'b1;
    run_txn(1, 3, 8'h00, 1'b0);
    req[1] = 1'b0;

    // Master error while idle: recovery with no err pulse and no grant
    @(negedge clk);
    inject_err = 1'b1;
    @(negedge clk);
    inject_err = 1'b0;
    c = 0;
    while (m_rst !== 1'b1 && c < 10) begin @(negedge clk); c++; end
    check("idle_err_busy", 32'(busy), 32'd1);
    check("idle_err_gnt",  32'(gnt),  32'd0);
    check("idle_err_err",  32'(err),  32'd0);
    k = 0;
    while (m_rst == 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("idle_err_rst_len", 32'(k), 32'(RST_CYCLES));

    // Requester drops its request mid-transaction: still completes
    rand_fields(2); req[2] = 1'b1;
    run_txn(2, 0, 8'($urandom), 1'b1);
    check("drop_req_state", 32'(req[2]), 32'd0);

    // Reset in the middle of a transaction
    req_addr[7 +: 7] = 7'h2B; req_rw[1] = 1'b1; req[1] = 1'b1;
    slave_mode = 0; slave_dur = 20;
    c = 0;
    do begin @(negedge clk); c++; end while (gnt == '0 && c < 50);
    check("mid_rst_gnt", 32'(gnt), 32'd2);
    repeat (4) @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    req = '0;
    rst = 1'b1;
    last_win  = NREQ - 1;
    exp_rdata = 8'h00;
    seen = '0;
    repeat (30) begin @(negedge clk); seen = seen | done | err; end
    check("mid_rst_no_pulse", 32'(seen), 32'd0);
    rand_fields(0); req[0] = 1'b1;
    run_txn(0, 0, 8'($urandom), 1'b0);
    req[0] = 1'b0;

    // Randomised traffic checked against the round-robin reference
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          rand_fields(i);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        w = $urandom_range(0, NREQ - 1);
        rand_fields(w);
        req[w] = 1'b1;
      end
      w = next_winner(last_win, req);
      m = $urandom_range(0, 9);
      mode = (m < 8) ? 0 : ((m == 8) ? 1 : 2);
      run_txn(w, mode, 8'($urandom), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
    end

    req = '0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
